// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: protocol FSM states,
// receiver states and word geometry.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    typedef enum logic [2:0] {
        RX_ARM,
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART byte receiver with a 2-flop rx synchroniser.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rx         raw serial input, idle high
//   data_byte  last received byte (valid with byte_valid)
//   byte_valid one-cycle pulse, good stop bit
//   frame_err  one-cycle pulse, stop bit sampled low (byte dropped)
//
// state    | meaning
// ---------+------------------------------------------------------
// RX_ARM   | wait for synchronised rx high before accepting a start
// RX_IDLE  | armed, a low level here is a start-bit falling edge
// RX_START | count to start-bit centre, reject glitches
// RX_BITS  | sample 8 data bits LSB first at bit centres
// RX_STOP  | sample stop bit, report byte or framing error
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= RX_ARM;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_ARM: begin
                    if (rx_sync) state <= RX_IDLE;
                end
                RX_IDLE: begin
                    // Only reachable after a high level, so low here is a falling edge.
                    if (!rx_sync) begin
                        timer <= HALF_M1;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rx_sync) begin
                        state <= RX_IDLE;
                    end else begin
                        timer   <= FULL_M1;
                        bit_cnt <= '0;
                        state   <= RX_BITS;
                    end
                end
                RX_BITS: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        timer   <= FULL_M1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        if (rx_sync) begin
                            data_byte  <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_ARM;
                    end
                end
                default: state <= RX_ARM;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed image over
// UART, writes it to memory word by word and releases the core on success.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   rx            UART serial input, idle high
//   mem_addr      byte address of current write (word index * 4)
//   mem_write_en  one-cycle write strobe
//   mem_write_val assembled little-endian word
//   core_run      1 releases the core
//   done          sticky, image loaded and verified
//   error         sticky, load failed
//
// state   | meaning
// --------+-----------------------------------------------
// ST_LEN0 | waiting for word count low byte
// ST_LEN1 | waiting for word count high byte, range check
// ST_DATA | assembling words, writing every 4th byte
// ST_CSUM | waiting for checksum byte
// ST_DONE | image verified, core released (terminal)
// ST_ERR  | load failed, core held (terminal)
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEM_WIDTH    = 32,
    parameter int MEM_SIZE     = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [31:0]          mem_addr,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    output logic                 core_run,
    output logic                 done,
    output logic                 error
);

    localparam logic [15:0] MAX_COUNT = 16'(MEM_SIZE);

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferr;
    boot_state_t          state;
    logic [15:0]          count;
    logic [15:0]          idx;
    logic [1:0]           byte_cnt;
    logic [7:0]           csum;
    logic [MEM_WIDTH-1:0] word;
    logic [15:0]          count_full;
    logic [15:0]          idx_next;
    logic [MEM_WIDTH-1:0] word_next;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_byte  (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    assign count_full = {rx_data, count[7:0]};
    assign idx_next   = idx + 16'd1;
    // Bytes arrive least significant first, so shift in from the top.
    assign word_next  = {rx_data, word[MEM_WIDTH-1:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_LEN0;
            count         <= '0;
            idx           <= '0;
            byte_cnt      <= '0;
            csum          <= '0;
            word          <= '0;
            mem_addr      <= '0;
            mem_write_en  <= 1'b0;
            mem_write_val <= '0;
            core_run      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            if (rx_ferr && state != ST_DONE && state != ST_ERR) begin
                error <= 1'b1;
                state <= ST_ERR;
            end else if (rx_valid) begin
                case (state)
                    ST_LEN0: begin
                        count[7:0] <= rx_data;
                        state      <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        count <= count_full;
                        if (count_full > MAX_COUNT) begin
                            error <= 1'b1;
                            state <= ST_ERR;
                        end else if (count_full == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        word     <= word_next;
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_write_en  <= 1'b1;
                            mem_addr      <= {14'd0, idx, 2'b00};
                            mem_write_val <= word_next;
                            idx           <= idx_next;
                            if (idx_next == count) state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == csum) begin
                            done     <= 1'b1;
                            core_run <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= ST_ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
    import uart_boot_loader_pkg::*;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_val;
    logic        core_run;
    logic        done;
    logic        error;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_WIDTH(32), .MEM_SIZE(256)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .core_run      (core_run),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] s_addr[$];
    logic [31:0] s_val[$];
    logic [31:0] e_addr[$];
    logic [31:0] e_val[$];
    logic        e_done;
    logic        e_err;

    int cyc = 0;
    int bv_count = 0;
    int bv_cycle = 0;
    int err_lat = -1;
    logic err_seen = 1'b0;

    // Observe strobes and receiver pulses away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_write_en) begin
            s_addr.push_back(mem_addr);
            s_val.push_back(mem_write_val);
        end
        if (dut.u_rx.byte_valid) begin
            bv_count = bv_count + 1;
            bv_cycle = cyc;
        end
        if (error && !err_seen) begin
            err_seen = 1'b1;
            err_lat  = cyc - bv_cycle;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        s_addr.delete();
        s_val.delete();
        bv_count = 0;
        err_seen = 1'b0;
        err_lat  = -1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
        repeat (CPB) @(posedge clk);
    endtask

    // Reference: interpret the byte stream by the wire protocol rules.
    task automatic model();
        int cnt;
        logic [7:0] x;
        e_addr.delete();
        e_val.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        if (tx_q.size() < 2) return;
        cnt = int'(tx_q[0]) + 256 * int'(tx_q[1]);
        if (cnt > 256) begin
            e_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < cnt; w++) begin
            if (tx_q.size() < 2 + 4 * w + 4) return;
            e_addr.push_back(32'(w * 4));
            e_val.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2], tx_q[2+4*w+1], tx_q[2+4*w]});
            for (int k = 0; k < 4; k++) x = x ^ tx_q[2+4*w+k];
        end
        if (tx_q.size() < 2 + 4 * cnt + 1) return;
        if (tx_q[2+4*cnt] == x) e_done = 1'b1;
        else e_err = 1'b1;
    endtask

    task automatic check_results(input string tag);
        int n;
        model();
        chk({tag, ".nstrobe"}, 32'(s_addr.size()), 32'(e_addr.size()));
        n = (s_addr.size() < e_addr.size()) ? s_addr.size() : e_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.addr%0d", tag, i), s_addr[i], e_addr[i]);
            chk($sformatf("%s.val%0d", tag, i), s_val[i], e_val[i]);
        end
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".error"}, 32'(error), 32'(e_err));
        chk({tag, ".core_run"}, 32'(core_run), 32'(e_done));
    endtask

    task automatic load_scen1(input logic [7:0] last);
        tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, last};
    endtask

    initial begin
        int cnt;
        logic [7:0] x;

        // Reset values while reset is held.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_write_en", 32'(mem_write_en), 32'h0);
        chk("rst.mem_write_val", mem_write_val, 32'h0);
        chk("rst.core_run", 32'(core_run), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.error", 32'(error), 32'h0);
        chk("rst.state", 32'(dut.state), 32'(ST_LEN0));

        // Normal load.
        do_reset(); clear_obs();
        load_scen1(8'h2A);
        send_all();
        check_results("normal");
        chk("normal.done_const", 32'(done), 32'h1);

        // Empty image.
        do_reset(); clear_obs();
        tx_q = '{8'h00, 8'h00, 8'h00};
        send_all();
        check_results("empty");

        // Oversize count, trailing bytes ignored.
        do_reset(); clear_obs();
        tx_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all();
        check_results("oversize");
        chk("oversize.err_latency", 32'(err_lat), 32'd1);

        // Bad checksum.
        do_reset(); clear_obs();
        load_scen1(8'h2B);
        send_all();
        check_results("badcsum");

        // Stop bit low on the 3rd byte.
        do_reset(); clear_obs();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        chk("framing.error", 32'(error), 32'h1);
        chk("framing.done", 32'(done), 32'h0);
        chk("framing.core_run", 32'(core_run), 32'h0);
        chk("framing.nstrobe", 32'(s_addr.size()), 32'h0);

        // Short low glitch: no byte, FSM stays in LEN0, then a normal load works.
        do_reset(); clear_obs();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        chk("glitch.byte_valid", 32'(bv_count), 32'h0);
        chk("glitch.state", 32'(dut.state), 32'(ST_LEN0));
        load_scen1(8'h2A);
        send_all();
        check_results("after_glitch");

        // Reset mid-bit during a partial load, then a full load.
        do_reset(); clear_obs();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        rx = 1'b0;
        repeat (CPB + CPB / 2 + 3) @(posedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst.state", 32'(dut.state), 32'(ST_LEN0));
        chk("midrst.mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        load_scen1(8'h2A);
        send_all();
        check_results("midrst");

        // Randomised images against the reference model.
        for (int it = 0; it < 6; it++) begin
            do_reset(); clear_obs();
            cnt = $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) cnt = 257 + $urandom_range(0, 3);
            tx_q.delete();
            tx_q.push_back(8'(cnt));
            tx_q.push_back(8'(cnt >> 8));
            x = 8'h00;
            if (cnt <= 256) begin
                for (int k = 0; k < 4 * cnt; k++) begin
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    x = x ^ tx_q[tx_q.size() - 1];
                end
                if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                tx_q.push_back(x);
            end
            tx_q.push_back(8'($urandom_range(0, 255)));
            send_all();
            check_results($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the board-level rx pin and the Core's instruction/data memory write port.
- Deserialises 8N1 UART bytes and assembles little-endian 32-bit words.
- Writes each word into memory through a single-cycle write strobe.
- Holds the Core stopped (core_run=0) until a complete, checksum-verified image has been loaded.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 8.
- MEM_WIDTH, 32, memory word width in bits; fixed at 32, 4 bytes per word.
- MEM_SIZE, 256, memory depth in words; largest legal word count.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, asynchronous to clk, idle high.
- mem_addr  out  32  byte address of the current write (word_index*4).
- mem_write_en  out  1  one-cycle write strobe.
- mem_write_val  out  32  assembled word.
- core_run  out  1  1 = Core released; 0 = Core held.
- done  out  1  sticky: image loaded and verified.
- error  out  1  sticky: load failed.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. clk and reset are the port names.
- Reset values: mem_addr=0, mem_write_en=0, mem_write_val=0, core_run=0, done=0, error=0. The rx synchroniser flops reset to 1. FSM state = LEN0.
- rx synchroniser: 2-flop synchroniser; only the synchronised value is used.
- Receiver arming: after reset, the receiver arms only once the synchronised rx has been sampled high. This prevents misframing when reset releases mid-frame.
- Start bit:
  - A falling edge starts the bit counter.
  - rx is re-sampled at CLKS_PER_BIT/2; if it is high, this is a glitch: return to idle, no byte.
- Data bits: 8 bits LSB first, each sampled at mid-bit (every CLKS_PER_BIT from the start-bit mid-sample).
- Stop bit:
  - Sampled at mid-bit.
  - Stop=1: byte_valid pulses for 1 cycle on the next clk.
  - Stop=0: frame_err pulses for 1 cycle and the byte is discarded.
  - The receiver then waits for rx high before re-arming.
- Wire protocol: count_lo, count_hi, then count*4 data bytes (each word little-endian), then 1 checksum byte = XOR of all data bytes (0x00 when count=0).
- FSM states and transitions:
  - LEN0: on byte, latch count[7:0] -> LEN1.
  - LEN1: on byte, latch count[15:8]. If count > MEM_SIZE -> ERR. Otherwise -> DATA, or -> CSUM if count==0.
  - DATA: on each byte, shift the byte into the word and XOR it into the checksum.
    - On the 4th byte: the next cycle drives mem_write_en=1, mem_addr=idx*4, mem_write_val=word. idx increments.
    - When idx reaches count -> CSUM.
    - mem_addr and mem_write_val hold their last values after the strobe.
  - CSUM: on byte, if it matches the running checksum -> DONE (done=1 and core_run=1 the cycle after byte_valid). Otherwise -> ERR.
  - DONE, ERR: terminal; all further rx traffic is ignored until reset. ERR sets error=1; core_run stays 0.
- Error paths: frame_err in any non-terminal state -> ERR.
- Write timing: one write per 4 bytes (>= 40 bit times apart), so strobes never collide.
- Counters: count is 16 bits; idx is 16 bits and never exceeds MEM_SIZE; mem_addr = {idx, 2'b00} zero-extended.
- Reset mid-operation: asserting reset in any state, including mid-bit or mid-word, aborts immediately to the reset values. Partial words are discarded; no write strobe is emitted.

Decomposition:
- Shared defines file holds:
  - FSM state codes (LEN0, LEN1, DATA, CSUM, DONE, ERR).
  - Receiver state codes (ARM, IDLE, START, BITS, STOP).
- Sub-module uart_rx_byte owns the synchroniser, the bit timing and framing. Its interface: clk, reset, rx -> byte[7:0], byte_valid, frame_err.
- uart_boot_loader holds the protocol FSM, word assembly, checksum and memory outputs.

Test Plan:
- CLKS_PER_BIT=16, MEM_SIZE=256 for all scenarios.
- Normal load: send 02 00 78 56 34 12 EF BE AD DE 2A -> two strobes, (0x0,0x12345678) then (0x4,0xDEADBEEF); done=1, core_run=1, error=0.
- Empty image: send 00 00 00 -> no strobes; done=1, core_run=1.
- Oversize count: send 01 01 (257) -> error=1 one cycle after 2nd byte_valid; no strobes; further bytes ignored; core_run=0.
- Bad checksum: scenario 1 with final byte 2B -> both strobes occur; error=1, done=0, core_run=0.
- Line faults:
  - Stop bit forced 0 on 3rd byte -> error=1, no strobes.
  - A separate run with rx low for 4 clocks, then high -> no byte_valid, state stays LEN0.
- Reset mid-load: send 02 00 78 56, pull reset low for 3 cycles mid-bit, release, then send scenario 1 -> results identical to scenario 1; no spurious strobe.
